// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory-port arbiter and the caches around it.
// Holds the arbiter state encoding, the requester indices and the default bus widths.
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    localparam int DEF_ADDRESS_SIZE = 32;
    localparam int DEF_LINE_LENGTH  = 128;

endpackage

// File: rtl/arb_pick.sv
// Grant selection between icache (0) and dcache (1); purely combinational.
// Latency: none. Backpressure: none, the caller samples the grant only when it can accept it.
// On a tie the requester that did not win last is chosen, so last_owner tied to 0 gives dcache-first.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic grant
);

    always_comb begin
        grant = REQ_ICACHE;
        if (req0 && req1) begin
            grant = ~last_owner;
        end else if (req1) begin
            grant = REQ_DCACHE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory line port between icache (0) and dcache (1); optional MEM_ARBITER_ROUND_ROBIN_EN.
// Latency: request to mem_req one cycle; one IDLE re-arbitration cycle after every completion or abort.
// Backpressure: the owner holds req until its satisfied pulse; dropping req while BUSY aborts the grant.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
    parameter int LINE_LENGTH  = DEF_LINE_LENGTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic [ADDRESS_SIZE-1:0] addr0,
    input  logic [LINE_LENGTH-1:0]  wdata0,
    input  logic                    write0,
    output logic                    satisfied0,
    input  logic                    req1,
    input  logic [ADDRESS_SIZE-1:0] addr1,
    input  logic [LINE_LENGTH-1:0]  wdata1,
    input  logic                    write1,
    output logic                    satisfied1,
    output logic [LINE_LENGTH-1:0]  result,
    output logic                    mem_req,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [LINE_LENGTH-1:0]  mem_data,
    output logic                    mem_write,
    input  logic [LINE_LENGTH-1:0]  mem_result,
    input  logic                    mem_satisfied,
    output logic                    owner,
    output logic                    busy
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       pick;
    logic       last_owner;
    logic       req_own;
    logic       done;

    arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_owner),
        .grant      (pick)
    );

    assign req_own = owner ? req1 : req0;
    assign done    = (state == BUSY) && mem_satisfied;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= REQ_ICACHE;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (req0 || req1)) begin
                owner <= pick;
            end
        end
    end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= REQ_DCACHE;
        end else if (done) begin
            last_owner <= owner;
        end
    end
`else
    assign last_owner = REQ_ICACHE;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req0 || req1) state_nxt = BUSY;
            BUSY: if (mem_satisfied || !req_own) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are squashed while reset is high so a completion coinciding with reset is dropped.
    always_comb begin
        busy        = (state == BUSY) && !reset;
        mem_req     = busy && req_own;
        mem_write   = mem_req && (owner ? write1 : write0);
        mem_address = busy ? (owner ? addr1 : addr0) : '0;
        mem_data    = busy ? (owner ? wdata1 : wdata0) : '0;
        satisfied0  = busy && (owner == REQ_ICACHE) && mem_satisfied;
        satisfied1  = busy && (owner == REQ_DCACHE) && mem_satisfied;
        result      = mem_result;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the grant rules.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0, write0 = 1'b0, write1 = 1'b0;
    logic [31:0]  addr0 = '0, addr1 = '0;
    logic [127:0] wdata0 = '0, wdata1 = '0, mem_result = '0;
    logic         mem_satisfied = 1'b0;
    logic         satisfied0, satisfied1, mem_req, mem_write, owner, busy;
    logic [31:0]  mem_address;
    logic [127:0] mem_data, result;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    // Model: is a grant outstanding, who holds it, who completed last.
    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_last = 1;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .write0(write0), .satisfied0(satisfied0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .write1(write1), .satisfied1(satisfied1),
        .result(result), .mem_req(mem_req), .mem_address(mem_address), .mem_data(mem_data),
        .mem_write(mem_write), .mem_result(mem_result), .mem_satisfied(mem_satisfied),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    always @(posedge clk) begin
        bit rq[2];
        rq[0] = req0;
        rq[1] = req1;
        if (reset) begin
            m_busy = 1'b0; m_owner = 0; m_last = 1;
        end else if (!m_busy) begin
            if (rq[0] && rq[1]) begin
                m_busy = 1'b1; m_owner = RR ? 1 - m_last : 1;
            end else if (rq[0] || rq[1]) begin
                m_busy = 1'b1; m_owner = rq[1] ? 1 : 0;
            end
        end else if (mem_satisfied) begin
            m_busy = 1'b0; m_last = m_owner;
        end else if (!rq[m_owner]) begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit eb, er;
            logic [31:0]  ea;
            logic [127:0] ed;
            eb = m_busy && !reset;
            er = eb && (m_owner == 1 ? req1 : req0);
            ea = eb ? (m_owner == 1 ? addr1 : addr0) : 32'd0;
            ed = eb ? (m_owner == 1 ? wdata1 : wdata0) : 128'd0;
            chk("m_busy", busy, eb);
            chk("m_mem_req", mem_req, er);
            chk("m_mem_address", mem_address, ea);
            chk("m_mem_data", mem_data, ed);
            chk("m_mem_write", mem_write, er && (m_owner == 1 ? write1 : write0));
            chk("m_satisfied0", satisfied0, eb && m_owner == 0 && mem_satisfied);
            chk("m_satisfied1", satisfied1, eb && m_owner == 1 && mem_satisfied);
            chk("m_result", result, mem_result);
            if (eb) chk("m_owner", owner, m_owner[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; write0 = 0; write1 = 0; mem_satisfied = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        cyc();
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_address", mem_address, 32'd0);
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int exp_g[4];
        cyc();
        cmp_en = 1'b1;
        do_reset();

        // Single read from icache, completion three cycles after mem_req.
        req0 = 1; addr0 = 32'h40; write0 = 0;
        @(negedge clk); chk("rd_idle_mem_req", mem_req, 1'b0);
        cyc();
        @(negedge clk);
        chk("rd_mem_req", mem_req, 1'b1);
        chk("rd_mem_address", mem_address, 32'h40);
        chk("rd_mem_write", mem_write, 1'b0);
        cyc(); cyc(); cyc();
        mem_satisfied = 1; mem_result = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        @(negedge clk);
        chk("rd_satisfied0", satisfied0, 1'b1);
        chk("rd_satisfied1", satisfied1, 1'b0);
        chk("rd_result", result, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        cyc();
        mem_satisfied = 0; req0 = 0;
        @(negedge clk);
        chk("rd_satisfied0_after", satisfied0, 1'b0);
        chk("rd_busy_after", busy, 1'b0);

        // Both requesters held across four transactions.
        do_reset();
        req0 = 1; req1 = 1; addr0 = 32'h100; addr1 = 32'h200;
        if (RR) begin exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1; end
        else    begin exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 1; end
        for (int k = 0; k < 4; k++) begin
            cyc();
            mem_satisfied = 1;
            @(negedge clk);
            chk("tie_owner", owner, exp_g[k][0]);
            chk("tie_mem_address", mem_address, exp_g[k] == 1 ? 32'h200 : 32'h100);
            chk("tie_satisfied", exp_g[k] == 1 ? satisfied1 : satisfied0, 1'b1);
            cyc();
            mem_satisfied = 0;
            if (k == 3) req1 = 0;
            @(negedge clk);
            chk("tie_idle_busy", busy, 1'b0);
        end
        cyc();
        @(negedge clk);
        chk("tie_then_owner0", owner, 1'b0);
        chk("tie_then_addr0", mem_address, 32'h100);

        // Dirty writeback followed by refill with req1 held throughout.
        do_reset();
        req1 = 1; write1 = 1; addr1 = 32'h80;
        wdata1 = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
        cyc();
        mem_satisfied = 1;
        @(negedge clk);
        chk("wb_mem_write", mem_write, 1'b1);
        chk("wb_mem_data", mem_data, 128'hDEADBEEF_0000_0000_0000_0000_0000_0001);
        chk("wb_satisfied1", satisfied1, 1'b1);
        cyc();
        mem_satisfied = 0; write1 = 0;
        @(negedge clk);
        chk("wb_gap_mem_req", mem_req, 1'b0);
        cyc();
        @(negedge clk);
        chk("refill_owner", owner, 1'b1);
        chk("refill_mem_req", mem_req, 1'b1);
        chk("refill_mem_write", mem_write, 1'b0);

        // Abort: icache drops its request before completion.
        do_reset();
        req0 = 1; addr0 = 32'h40;
        cyc();
        cyc();
        req0 = 0;
        @(negedge clk);
        chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_satisfied0", satisfied0, 1'b0);
        cyc();
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);

        // Reset arriving together with a completion.
        do_reset();
        req1 = 1;
        cyc();
        cyc();
        reset = 1; mem_satisfied = 1;
        @(negedge clk);
        chk("rstmid_satisfied1", satisfied1, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_mem_req", mem_req, 1'b0);
        cyc();
        reset = 0; mem_satisfied = 0; req1 = 0; req0 = 1;
        @(negedge clk);
        chk("rstmid_after_busy", busy, 1'b0);
        cyc();
        @(negedge clk);
        chk("rstmid_regrant_busy", busy, 1'b1);
        chk("rstmid_regrant_owner", owner, 1'b0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            cyc();
            reset = ($urandom_range(99) == 0);
            if ($urandom_range(3) == 0) req0 = ~req0;
            if ($urandom_range(3) == 0) req1 = ~req1;
            write0 = $urandom_range(1);
            write1 = $urandom_range(1);
            addr0 = $urandom;
            addr1 = $urandom;
            wdata0 = {$urandom, $urandom, $urandom, $urandom};
            wdata1 = {$urandom, $urandom, $urandom, $urandom};
            mem_result = {$urandom, $urandom, $urandom, $urandom};
            mem_satisfied = ($urandom_range(3) == 0);
        end
        cyc();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
